// File: rtl/pin_input_conditioner.sv
// Per-pin synchronizer plus programmable glitch filter with registered rise/fall strobes.
// Latency: a stable raw change reaches pin_in SYNC_STAGES+filt_len+1 edges after first sample.
// Backpressure: none; free-running, every pin updates each clock.
module pin_input_conditioner #(
    parameter int   WIDTH       = 32,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_BITS   = 4,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                 clock_160,
    input  logic                 inp_resn,
    input  logic [WIDTH-1:0]     pin_raw,
    input  logic [FILT_BITS-1:0] filt_len,
    output logic [WIDTH-1:0]     pin_in,
    output logic [WIDTH-1:0]     pin_rise,
    output logic [WIDTH-1:0]     pin_fall,
    output logic                 changed
);
    localparam logic [FILT_BITS-1:0] CNT_ONE = FILT_BITS'(1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][FILT_BITS-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]                  pin_in_q, pin_in_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic                              changed_q, changed_d;
    logic [WIDTH-1:0]                  s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_raw};
        s      = sync_q[SYNC_STAGES-1];
    end

    // cnt counts consecutive edges s has disagreed with pin_in; it can only
    // climb while below filt_len, so it is bounded by the counter width.
    always_comb begin
        pin_in_d = pin_in_q;
        cnt_d    = cnt_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == pin_in_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= filt_len) begin
                pin_in_d[i] = s[i];
                cnt_d[i]    = '0;
                rise_d[i]   = s[i];
                fall_d[i]   = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            sync_q    <= {(SYNC_STAGES*WIDTH){RESET_LEVEL}};
            cnt_q     <= '0;
            pin_in_q  <= {WIDTH{RESET_LEVEL}};
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            pin_in_q  <= pin_in_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign pin_in   = pin_in_q;
    assign pin_rise = rise_q;
    assign pin_fall = fall_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Directed bench for pin_input_conditioner with a history-scanning reference model.
module tb_pin_input_conditioner;
    localparam int   W     = 32;
    localparam int   SYNC  = 2;
    localparam int   FB    = 4;
    localparam logic RSTLV = 1'b0;

    logic          clk = 1'b0;
    logic          inp_resn = 1'b0;
    logic [W-1:0]  pin_raw = '0;
    logic [FB-1:0] filt_len = '0;
    logic [W-1:0]  pin_in, pin_rise, pin_fall;
    logic          changed;

    int checks = 0;
    int errors = 0;

    pin_input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .FILT_BITS(FB), .RESET_LEVEL(RSTLV)
    ) dut (
        .clock_160(clk),
        .inp_resn (inp_resn),
        .pin_raw  (pin_raw),
        .filt_len (filt_len),
        .pin_in   (pin_in),
        .pin_rise (pin_rise),
        .pin_fall (pin_fall),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    // Reference model: keeps the raw samples and the synchronized value seen
    // at every edge since reset; a pin flips once the run of edges on which the
    // synchronized value disagreed with the level is longer than filt_len.
    logic [W-1:0] raw_q [$];
    logic [W-1:0] s_log [$];
    logic [W-1:0] m_lvl, m_rise, m_fall, s_now;
    logic         m_chg;
    int           n_idx, run;

    task automatic m_reset();
        raw_q.delete();
        s_log.delete();
        for (int k = 0; k < SYNC; k++) raw_q.push_back({W{RSTLV}});
        m_lvl  = {W{RSTLV}};
        m_rise = '0;
        m_fall = '0;
        m_chg  = 1'b0;
    endtask

    always @(posedge clk or negedge inp_resn) begin
        if (!inp_resn) begin
            m_reset();
        end else begin
            s_now = raw_q[SYNC-1];
            s_log.push_back(s_now);
            n_idx  = s_log.size() - 1;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                run = 0;
                for (int j = n_idx; j >= 0 && s_log[j][i] != m_lvl[i]; j--) run++;
                if (run > 0 && (run - 1) >= int'(filt_len)) begin
                    m_lvl[i]  = s_now[i];
                    m_rise[i] = s_now[i];
                    m_fall[i] = ~s_now[i];
                end
            end
            m_chg = |(m_rise | m_fall);
            raw_q.push_front(pin_raw);
            void'(raw_q.pop_back());
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_pin_in", pin_in, m_lvl);
        chk("model_pin_rise", pin_rise, m_rise);
        chk("model_pin_fall", pin_fall, m_fall);
        chk("model_changed", {31'd0, changed}, {31'd0, m_chg});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // 1: reset held while raw pins toggle
        cyc(1);
        pin_raw = 32'hA5A5_5A5A;
        cyc(1);
        chk("rst_pin_in", pin_in, 32'h0);
        chk("rst_rise", pin_rise, 32'h0);
        pin_raw = '1;
        cyc(2);
        chk("rst_fall", pin_fall, 32'h0);
        chk("rst_changed", {31'd0, changed}, 32'h0);
        pin_raw  = '0;
        inp_resn = 1'b1;
        cyc(4);

        // 2: unfiltered, pin 5 rises
        filt_len   = 4'd0;
        pin_raw[5] = 1'b1;
        cyc(2);
        chk("t2_e2_pin_in", pin_in, 32'h0);
        cyc(1);
        chk("t2_e3_pin_in", pin_in, 32'h20);
        chk("t2_e3_rise", pin_rise, 32'h20);
        chk("t2_e3_changed", {31'd0, changed}, 32'h1);
        cyc(1);
        chk("t2_e4_rise", pin_rise, 32'h0);
        chk("t2_e4_changed", {31'd0, changed}, 32'h0);
        pin_raw = '0;
        cyc(6);

        // 3: filt_len 3, 3-cycle pulse rejected, 4-cycle pulse passes
        filt_len   = 4'd3;
        pin_raw[0] = 1'b1;
        cyc(3);
        pin_raw[0] = 1'b0;
        cyc(3);
        chk("t3_short_pin_in", pin_in, 32'h0);
        cyc(4);
        pin_raw[0] = 1'b1;
        cyc(4);
        pin_raw[0] = 1'b0;
        cyc(1);
        chk("t3_e5_pin_in", pin_in, 32'h0);
        cyc(1);
        chk("t3_e6_pin_in", pin_in, 32'h1);
        chk("t3_e6_rise", pin_rise, 32'h1);
        cyc(4);
        chk("t3_e10_fall", pin_fall, 32'h1);
        chk("t3_e10_pin_in", pin_in, 32'h0);
        cyc(1);
        chk("t3_e11_fall", pin_fall, 32'h0);
        cyc(4);

        // 4: filt_len lowered from 15 to 4 with count at 10
        filt_len   = 4'd15;
        pin_raw[1] = 1'b1;
        cyc(12);
        chk("t4_e12_pin_in", pin_in, 32'h0);
        filt_len = 4'd4;
        cyc(1);
        chk("t4_e13_pin_in", pin_in, 32'h2);
        chk("t4_e13_rise", pin_rise, 32'h2);
        cyc(1);
        chk("t4_e14_rise", pin_rise, 32'h0);
        pin_raw = '0;
        cyc(10);

        // 5: all pins together, filt_len 2
        filt_len = 4'd2;
        pin_raw  = '1;
        cyc(4);
        chk("t5_e4_pin_in", pin_in, 32'h0);
        cyc(1);
        chk("t5_e5_rise", pin_rise, 32'hFFFF_FFFF);
        chk("t5_e5_fall", pin_fall, 32'h0);
        chk("t5_e5_changed", {31'd0, changed}, 32'h1);
        cyc(1);
        chk("t5_e6_rise", pin_rise, 32'h0);
        pin_raw = '0;
        cyc(6);
        chk("t5_back_pin_in", pin_in, 32'h0);

        // 6: reset pulse mid-filter restarts the count
        filt_len   = 4'd5;
        pin_raw[2] = 1'b1;
        cyc(4);
        #2 inp_resn = 1'b0;
        cyc(1);
        chk("t6_rst_pin_in", pin_in, 32'h0);
        chk("t6_rst_rise", pin_rise, 32'h0);
        cyc(1);
        inp_resn = 1'b1;
        cyc(1);
        chk("t6_rel_rise", pin_rise, 32'h0);
        chk("t6_rel_changed", {31'd0, changed}, 32'h0);
        cyc(6);
        chk("t6_e7_pin_in", pin_in, 32'h0);
        cyc(1);
        chk("t6_e8_pin_in", pin_in, 32'h4);
        chk("t6_e8_rise", pin_rise, 32'h4);
        pin_raw = '0;
        cyc(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
